// File: rtl/sample_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module  : sample_capture_buffer
// Purpose : Ping-pong capture of the audio sample stream for FFT_block reads.
// Revision: 1.0 - initial release
// ============================================================================
module sample_capture_buffer #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_NUM   = 1024,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SAMPLE_WIDTH-1:0] sample_i,
   input  logic                    sample_valid_i,
   input  logic [ADDR_WIDTH-1:0]   address_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    start_o,
   input  logic                    fft_done_i,
   output logic                    overflow_o,
   output logic [15:0]             drop_cnt_o
);

   localparam logic [0:0] ST_FILL      = 1'b0;
   localparam logic [0:0] ST_FULL_WAIT = 1'b1;
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(SAMPLE_NUM - 1);

   logic [DATA_WIDTH-1:0] mem_q [0:2*SAMPLE_NUM-1];

   logic [0:0]            state_q, state_d;
   logic                  wr_bank_q, wr_bank_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic                  rd_busy_q, rd_busy_d;
   logic                  start_q, start_d;
   logic                  overflow_q, overflow_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  wr_en, drop, swap;
   logic [DATA_WIDTH-1:0] wr_data;

   always_comb begin
      state_d    = state_q;
      wr_bank_d  = wr_bank_q;
      wr_ptr_d   = wr_ptr_q;
      rd_busy_d  = rd_busy_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      start_d    = 1'b0;
      wr_en      = 1'b0;
      drop       = 1'b0;
      swap       = 1'b0;
      wr_data    = {{(DATA_WIDTH-SAMPLE_WIDTH){sample_i[SAMPLE_WIDTH-1]}}, sample_i};

      case (state_q)
         ST_FILL: begin
            if (sample_valid_i) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == LAST_PTR) begin
                  wr_ptr_d = '0;
                  // A release arriving with the final sample frees the read bank in time.
                  if (!rd_busy_q || fft_done_i) begin
                     swap = 1'b1;
                  end else begin
                     state_d = ST_FULL_WAIT;
                  end
               end
            end
         end
         ST_FULL_WAIT: begin
            drop = sample_valid_i;
            if (!rd_busy_q || fft_done_i) begin
               swap     = 1'b1;
               state_d  = ST_FILL;
               wr_ptr_d = '0;
            end
         end
         default: state_d = ST_FILL;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end

      if (swap) begin
         wr_bank_d = ~wr_bank_q;
         start_d   = 1'b1;
         rd_busy_d = 1'b1;
      end else if (fft_done_i) begin
         rd_busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[{wr_bank_q, wr_ptr_q}] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_FILL;
         wr_bank_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_busy_q  <= 1'b0;
         start_q    <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_busy_q  <= rd_busy_d;
         start_q    <= start_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         // Reads follow the current read bank, so a swap is visible on the next read issued.
         data_q     <= mem_q[{~wr_bank_q, address_i}];
      end
   end

   assign data_o     = data_q;
   assign start_o    = start_q;
   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sample_capture_buffer
// Purpose : Directed bench for sample_capture_buffer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sample_capture_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] sample_i = '0;
   logic        sample_valid_i = 1'b0;
   logic [9:0]  address_i = '0;
   logic [31:0] data_o;
   logic        start_o;
   logic        fft_done_i = 1'b0;
   logic        overflow_o;
   logic [15:0] drop_cnt_o;

   int n_assert = 0;
   int n_fail   = 0;
   int start_cnt = 0;

   sample_capture_buffer #(
      .SAMPLE_WIDTH(16), .DATA_WIDTH(32), .SAMPLE_NUM(1024), .ADDR_WIDTH(10)
   ) dut (
      .clk(clk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
      .address_i(address_i), .data_o(data_o), .start_o(start_o),
      .fft_done_i(fft_done_i), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (start_o) start_cnt++;
   endtask

   task automatic push(input logic [15:0] v);
      sample_i       = v;
      sample_valid_i = 1'b1;
      tick();
      sample_valid_i = 1'b0;
   endtask

   task automatic rd(input logic [9:0] a, output logic [31:0] d);
      address_i = a;
      tick();
      d = data_o;
   endtask

   initial begin
      logic [31:0] d;
      int s0, since, pf, loop_starts;
      bit pend;

      // 1: asynchronous reset asserted mid-cycle
      #13 rst = 1'b1;
      #1;
      chk("rst_data", data_o, 32'h0);
      chk("rst_start", start_o, 32'h0);
      chk("rst_ovf", overflow_o, 32'h0);
      chk("rst_drop", drop_cnt_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 2: first frame, value = index
      for (int i = 0; i < 1023; i++) push(16'(i));
      chk("t2_no_early_start", start_cnt, 32'd0);
      push(16'd1023);
      chk("t2_start", start_o, 32'd1);
      rd(10'd5, d);
      chk("t2_rd5", d, 32'd5);
      chk("t2_start_one_cycle", start_o, 32'd0);
      rd(10'd1023, d);
      chk("t2_rd1023", d, 32'd1023);

      // 3: second frame without release -> FULL_WAIT and drops
      for (int i = 0; i < 1024; i++) push(16'h8000 | 16'(i));
      chk("t3_no_start", start_cnt, 32'd1);
      chk("t3_no_ovf_yet", overflow_o, 32'd0);
      for (int i = 0; i < 10; i++) push(16'h7777);
      chk("t3_ovf", overflow_o, 32'd1);
      chk("t3_drop", drop_cnt_o, 32'd10);
      chk("t3_still_no_start", start_cnt, 32'd1);
      rd(10'd5, d);
      chk("t3_old_bank", d, 32'd5);
      fft_done_i = 1'b1;
      tick();
      fft_done_i = 1'b0;
      chk("t3_start", start_o, 32'd1);
      rd(10'd0, d);
      chk("t3_sext", d, 32'hFFFF8000);
      rd(10'd5, d);
      chk("t3_rd5", d, 32'hFFFF8005);
      chk("t3_start_cnt", start_cnt, 32'd2);

      // 4: frame completes in the same cycle as fft_done_i
      for (int i = 0; i < 1023; i++) push(16'h1000 + 16'(i));
      fft_done_i = 1'b1;
      push(16'h13FF);
      fft_done_i = 1'b0;
      chk("t4_start", start_o, 32'd1);
      chk("t4_drop", drop_cnt_o, 32'd10);
      rd(10'd3, d);
      chk("t4_rd3", d, 32'h1003);

      // 5: continuous stream for 3 frames, release 200 cycles after each start
      since = 0; pf = 0; pend = 1'b0; loop_starts = 0;
      for (int c = 0; c < 3072; c++) begin
         sample_i       = 16'(32'h2000 + c);
         sample_valid_i = 1'b1;
         fft_done_i     = (since == 200);
         address_i      = 10'd17;
         tick();
         since++;
         if (pend) begin
            chk("t5_data", data_o, 32'h2000 + 32'(pf * 1024) + 32'd17);
            pend = 1'b0;
         end
         if (start_o) begin
            chk("t5_start_pos", 32'((c + 1) % 1024), 32'd0);
            pf = c / 1024;
            pend = 1'b1;
            since = 0;
            loop_starts++;
         end
      end
      sample_valid_i = 1'b0;
      fft_done_i     = 1'b0;
      tick();
      if (pend) chk("t5_data", data_o, 32'h2000 + 32'(pf * 1024) + 32'd17);
      chk("t5_starts", loop_starts, 32'd3);
      chk("t5_drop", drop_cnt_o, 32'd10);

      // 6: reset mid-frame discards the partial frame
      for (int i = 0; i < 500; i++) push(16'h5555);
      #3 rst = 1'b1;
      #1;
      chk("t6_rst_ovf", overflow_o, 32'd0);
      chk("t6_rst_drop", drop_cnt_o, 32'd0);
      chk("t6_rst_data", data_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      s0 = start_cnt;
      for (int i = 0; i < 1023; i++) push(16'h3000 + 16'(i));
      chk("t6_no_early_start", start_cnt, 32'(s0));
      push(16'h33FF);
      chk("t6_start", start_o, 32'd1);
      chk("t6_drop", drop_cnt_o, 32'd0);
      rd(10'd5, d);
      chk("t6_rd5", d, 32'h3005);
      rd(10'd1023, d);
      chk("t6_rd1023", d, 32'h33FF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
